mips_div_unit: RTL

- Multi-cycle iterative restoring divider for the MIPS DIV/DIVU instructions. It produces the quotient (LO) and remainder (HI).
- It is the inverse of the datapath adder/multiplier path. It is built from the same (W+1)-bit subtract-with-borrow step: the borrow bit decides each quotient bit.
- It sits beside the ALU in EX and is started by the control unit. The pipeline stalls on busy.

---
 rtl/mips_div_pkg.sv | 29 ++
 rtl/mips_div_unit_sub_step.sv | 30 +++
 rtl/mips_div_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mips_div_pkg.sv
// Shared types and constants for the MIPS DIV/DIVU iterative divider.
package mips_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        SIGNFIX,
        FINISH
    } div_state_e;

    localparam int DIV_WIDTH_DEFAULT = 32;

    localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV0_QUOTIENT = '1;

    // Bits needed to hold 0..value-1 (the iteration counter).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_div_unit_sub_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference when no borrow occurs.
module div_sub_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH+1:0] w_wide;
    logic             w_borrow;
    logic             w_unused_top;

    assign w_shifted = {i_rem[WIDTH-2:0], i_bit};

    // The old remainder MSB is the extra (W+1)th bit of the shifted value.
    assign w_wide   = {1'b0, i_rem[WIDTH-1], w_shifted} - {2'b00, i_divisor};
    assign w_borrow = w_wide[WIDTH+1];

    // Bit WIDTH of a borrow-free difference is always zero (diff < divisor).
    assign w_unused_top = w_wide[WIDTH];

    assign o_qbit = ~w_borrow;
    assign o_rem  = w_borrow ? w_shifted : w_wide[WIDTH-1:0];

endmodule

// File: rtl/mips_div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU (LO = quotient, HI = remainder).
// Optional MIPS_DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module mips_div_unit
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW_RAW = clog2(WIDTH);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DIV0_Q    = {WIDTH{DIV0_QUOTIENT[0]}};
    localparam logic [CW-1:0]    CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_START = CW'(WIDTH - 1);

    div_state_e r_state;
    div_state_e w_next;

    logic             r_signed;
    logic [WIDTH-1:0] r_dvd_raw;
    logic [WIDTH-1:0] r_dvs_raw;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [WIDTH-1:0] r_dvs_mag;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_dvs_zero;
    logic             w_early;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_qbit;

    // Magnitudes are derived from the operands latched at acceptance.
    assign w_dvd_neg  = r_signed & r_dvd_raw[WIDTH-1];
    assign w_dvs_neg  = r_signed & r_dvs_raw[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? (~r_dvd_raw + ONE) : r_dvd_raw;
    assign w_dvs_mag  = w_dvs_neg ? (~r_dvs_raw + ONE) : r_dvs_raw;
    assign w_dvs_zero = (r_dvs_raw == '0);

`ifdef MIPS_DIV_EARLY_OUT_EN
    assign w_early = (w_dvd_mag < w_dvs_mag);
`else
    assign w_early = 1'b0;
`endif

    div_sub_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quo[WIDTH-1]),
        .i_divisor (r_dvs_mag),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = LOAD;
            end
            LOAD: begin
                if (w_dvs_zero || w_early) w_next = FINISH;
                else                       w_next = CALC;
            end
            CALC: begin
                if (r_cnt == '0) w_next = SIGNFIX;
            end
            SIGNFIX: w_next = FINISH;
            FINISH: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_signed    <= 1'b0;
            r_dvd_raw   <= '0;
            r_dvs_raw   <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_dvs_mag   <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_signed  <= is_signed;
                        r_dvd_raw <= dividend;
                        r_dvs_raw <= divisor;
                    end
                end
                LOAD: begin
                    r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
                    r_r_neg   <= w_dvd_neg;
                    r_dvs_mag <= w_dvs_mag;
                    r_quo     <= w_dvd_mag;
                    r_rem     <= '0;
                    r_cnt     <= CNT_START;
                    if (w_dvs_zero) begin
                        r_quotient  <= DIV0_Q;
                        r_remainder <= r_dvd_raw;
                        r_dbz       <= 1'b1;
                    end else if (w_early) begin
                        r_quotient  <= '0;
                        r_remainder <= r_dvd_raw;
                        r_dbz       <= 1'b0;
                    end
                end
                CALC: begin
                    // Dividend bits leave the top of r_quo as quotient bits enter below.
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_step_qbit};
                    r_cnt <= r_cnt - CNT_ONE;
                end
                SIGNFIX: begin
                    r_quotient  <= r_q_neg ? (~r_quo + ONE) : r_quo;
                    r_remainder <= r_r_neg ? (~r_rem + ONE) : r_rem;
                    r_dbz       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
